ps2_kbd_cmd_sched: RTL and testbench
====================================

// Module: ps2_kbd_cmd_sched
// PURPOSE
//  Command scheduler in front of ps2_kbd_host: sole driver of its kbd_wcmddata/enq_cmd1/enq_cmd2 inputs.
//  Arbitrates keyboard init (on BAT OK), CPU commands and automatic LED updates; tracks kbd_stat to completion.
//  Applies timeout/retry and reports per-transaction status to the CPU register block.
// PARAMETERS
//  TIMEOUT_MS     20     ms without ACK/ERR before a try is abandoned (1..255)
//  MAX_RETRY      2      extra tries after ERR or timeout (0..3)
//  DEF_TYPEMATIC  8'h20  data byte sent with F3 during init
// PORTS
//  clk6x           in   1  48 MHz clock
//  resetn          in   1  sync reset, active low
//  ck1us           in   1  1-cycle pulse every 1 us
//  kbd_stat_i      in   8  host reply status: 00 idle, 01 pending, FA ack, FE err
//  kbd_bat_ok_i    in   1  1-cycle pulse, BAT OK (AA) received
//  kbd_wcmddata_o  out  8  byte to host TX FIFO
//  kbd_enq_cmd1_o  out  1  1-cycle enqueue, 1B cmd or 2nd byte of 2B
//  kbd_enq_cmd2_o  out  1  1-cycle enqueue, 1st byte of 2B cmd+data
//  host_clr_o      out  1  1-cycle pulse, top ANDs !host_clr_o into host resetn
//  cpu_req_i       in   1  1-cycle request; accepted only when cpu_busy_o=0
//  cpu_len2_i      in   1  1 = cmd+data, 0 = cmd only (sampled with cpu_req_i)
//  cpu_cmd_i       in   8  command byte (sampled with cpu_req_i)
//  cpu_data_i      in   8  data byte (sampled with cpu_req_i)
//  cpu_busy_o      out  1  CPU request latched and not yet completed
//  cpu_stat_o      out  8  00 idle, 01 pending, FA ack, FE err, FD timeout
//  led_i           in   3  desired {caps,num,scroll}
//  init_done_o     out  1  init sequence finished
//  init_err_o      out  1  sticky: some init step failed; cleared on bat_ok
// BEHAVIOUR
//  Reset: all outputs 0, cpu_stat_o=00, led_sent=000, step=0, retry=0, FSM IDLE. AUTO init not started until bat_ok.
//  Sources, fixed priority in IDLE: INIT > CPU > LED. Selection evaluated only in IDLE; no preemption except bat_ok.
//  INIT steps: 0: F3,DEF_TYPEMATIC (2B); 1: ED,{5'b0,led_i} (2B, on ACK led_sent<=led_i); 2: F4 (1B).
//   Each step runs to ACK or final failure (sets init_err_o), then next step; after step 2 init_done_o<=1.
//  LED: when init_done_o && led_i!=led_sent -> ED,{5'b0,led_i}; led_sent<=sampled value on completion, pass or fail.
//  CPU: cpu_req_i && !cpu_busy_o latches len2/cmd/data; next cycle cpu_busy_o=1, cpu_stat_o=01.
//   Completion: cpu_stat_o=FA/FE/FD, cpu_busy_o=0 same cycle.
//  FSM: IDLE -> ISSUE0 -> [ISSUE1 if 2B] -> WAIT -> (IDLE | RETRY).
//   ISSUE0: 1 cycle, wdata=cmd, enq_cmd2_o=1 if 2B else enq_cmd1_o=1.
//   ISSUE1: next cycle, wdata=data, enq_cmd1_o=1. enq pulses never overlap; never two txns in flight.
//   WAIT: entered cycle after last enq (host stat already 01). stat==FA -> success; stat==FE -> fail-try;
//    ms counter reaches TIMEOUT_MS -> timeout-try. Any other stat value: keep waiting.
//   Timeout-try: host_clr_o=1 for 1 cycle on WAIT exit. ERR-try: no clear (host already flushes TX FIFO).
//   RETRY: if retry<MAX_RETRY: retry++, 1 idle cycle, re-issue same bytes from ISSUE0. Else final failure
//    (FE if last try ERR, FD if timeout), retry<=0, IDLE. Success also clears retry.
//  Timer: 10-bit us prescaler on ck1us -> ms tick every 1000 pulses; 8-bit ms count; both cleared on WAIT entry.
//   Timeout fires when ms count == TIMEOUT_MS (first ms may be partial: granularity -1 ms/+0).
//  bat_ok (any state): host_clr_o pulse, abort active txn (CPU -> FE, LED -> led_sent unchanged),
//   init_done_o=0, init_err_o=0, step=0, retry=0, IDLE next cycle. A CPU request latched but not started stays queued.
//  Simultaneous: cpu_req_i with bat_ok -> request latched, runs after init. led_i change mid-txn -> handled after.
//  Stale stat: kbd_stat_i only evaluated in WAIT; FA left from earlier txns ignored.
// STRUCTURE
//  Package ps2_kbd_pkg: stat codes (00,01,FA,FE,FD), PS2 cmd bytes (F3,ED,F4,AA), FSM state enum, source enum.
//  One sub-module: ps2_ms_timer (ck1us -> ms tick, clear, count, terminal flag). Rest single always block.
// TESTING (bench models host kbd_stat with configurable reply delay)
//  bat_ok, all ACK in 3 ms -> enq seq F3(cmd2),20(cmd1),ED,00,F4(cmd1); init_done_o=1, init_err_o=0.
//  cpu_req cmd=F2 len2=0, host ACK after 5 ms -> single enq_cmd1 F2; cpu_stat 01 then FA; busy 1->0.
//  CPU 2B ED,07, reply FE twice then FA, MAX_RETRY=2 -> 3 issues, no host_clr_o, cpu_stat=FA.
//  No reply, TIMEOUT_MS=20 -> host_clr_o pulse at 20 ms (+-1), 3 tries total, cpu_stat=FD at ~60 ms.
//  led_i 000->100 after init -> ED,04 sent once; second write of same led_i -> no traffic.
//  bat_ok mid-WAIT of CPU txn -> cpu_stat=FE, host_clr_o pulse, init restarts at F3; reset mid-op -> all outputs reset.

Source files
------------

// File: rtl/ps2_kbd_pkg.sv
// Shared codes for the PS/2 keyboard command scheduler: status bytes, keyboard
// command bytes, FSM states and transaction sources.
package ps2_kbd_pkg;

    localparam logic [7:0] STAT_IDLE = 8'h00;
    localparam logic [7:0] STAT_PEND = 8'h01;
    localparam logic [7:0] STAT_ACK  = 8'hFA;
    localparam logic [7:0] STAT_ERR  = 8'hFE;
    localparam logic [7:0] STAT_TMO  = 8'hFD;

    localparam logic [7:0] CMD_TYPEMATIC = 8'hF3;
    localparam logic [7:0] CMD_SET_LED   = 8'hED;
    localparam logic [7:0] CMD_ENABLE    = 8'hF4;
    localparam logic [7:0] KBD_BAT_OK    = 8'hAA;

    localparam logic [9:0] US_PER_MS_M1 = 10'd999;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE0,
        ST_ISSUE1,
        ST_WAIT,
        ST_RETRY
    } state_e;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_INIT,
        SRC_CPU,
        SRC_LED
    } src_e;

endpackage

// File: rtl/ps2_ms_timer.sv
// Millisecond timeout timer: divides the 1 us strobe down to ms and flags when
// the ms count reaches the configured limit.
module ps2_ms_timer
    import ps2_kbd_pkg::*;
#(
    parameter int TIMEOUT_MS = 20
) (
    input  logic clk6x,
    input  logic resetn,
    input  logic ck1us,
    input  logic clr,
    output logic done_o
);

    logic [9:0] us_q, us_d;
    logic [7:0] ms_q, ms_d;
    logic       ms_tick;

    always_comb begin
        ms_tick = ck1us && (us_q == US_PER_MS_M1);
        us_d    = us_q;
        ms_d    = ms_q;
        if (clr) begin
            us_d = '0;
            ms_d = '0;
        end else if (ck1us) begin
            us_d = ms_tick ? 10'd0 : us_q + 10'd1;
            // Saturate so a stuck count can never wrap back below the limit.
            if (ms_tick && ms_q != 8'hFF) begin
                ms_d = ms_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk6x) begin
        if (!resetn) begin
            us_q <= '0;
            ms_q <= '0;
        end else begin
            us_q <= us_d;
            ms_q <= ms_d;
        end
    end

    assign done_o = (ms_q == 8'(TIMEOUT_MS));

endmodule

// File: rtl/ps2_kbd_cmd_sched.sv
// Schedules keyboard init, CPU commands and LED updates onto the PS/2 host,
// one transaction at a time, with ms timeout and bounded retry.
module ps2_kbd_cmd_sched
    import ps2_kbd_pkg::*;
#(
    parameter int         TIMEOUT_MS    = 20,
    parameter int         MAX_RETRY     = 2,
    parameter logic [7:0] DEF_TYPEMATIC = 8'h20
) (
    input  logic       clk6x,
    input  logic       resetn,
    input  logic       ck1us,
    input  logic [7:0] kbd_stat_i,
    input  logic       kbd_bat_ok_i,
    output logic [7:0] kbd_wcmddata_o,
    output logic       kbd_enq_cmd1_o,
    output logic       kbd_enq_cmd2_o,
    output logic       host_clr_o,
    input  logic       cpu_req_i,
    input  logic       cpu_len2_i,
    input  logic [7:0] cpu_cmd_i,
    input  logic [7:0] cpu_data_i,
    output logic       cpu_busy_o,
    output logic [7:0] cpu_stat_o,
    input  logic [2:0] led_i,
    output logic       init_done_o,
    output logic       init_err_o
);

    state_e     state_q, state_d;
    src_e       src_q, src_d;
    logic [1:0] step_q, step_d;
    logic [1:0] retry_q, retry_d;
    logic       init_run_q, init_run_d;
    logic       init_done_q, init_done_d;
    logic       init_err_q, init_err_d;
    logic [2:0] led_sent_q, led_sent_d;
    logic       tx_len2_q, tx_len2_d;
    logic [7:0] tx_cmd_q, tx_cmd_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic       last_err_q, last_err_d;
    logic       host_clr_q, host_clr_d;
    logic       cpu_busy_q, cpu_busy_d;
    logic       cpu_len2_q, cpu_len2_d;
    logic [7:0] cpu_cmd_q, cpu_cmd_d;
    logic [7:0] cpu_data_q, cpu_data_d;
    logic [7:0] cpu_stat_q, cpu_stat_d;

    logic tmr_clr, tmr_done, txn_end, txn_pass;

    // Timer restarts on the last enqueue so WAIT always begins at zero.
    assign tmr_clr = (state_q == ST_ISSUE0 && !tx_len2_q) || (state_q == ST_ISSUE1);

    ps2_ms_timer #(.TIMEOUT_MS(TIMEOUT_MS)) u_timer (
        .clk6x  (clk6x),
        .resetn (resetn),
        .ck1us  (ck1us),
        .clr    (tmr_clr),
        .done_o (tmr_done)
    );

    always_comb begin
        state_d     = state_q;
        src_d       = src_q;
        step_d      = step_q;
        retry_d     = retry_q;
        init_run_d  = init_run_q;
        init_done_d = init_done_q;
        init_err_d  = init_err_q;
        led_sent_d  = led_sent_q;
        tx_len2_d   = tx_len2_q;
        tx_cmd_d    = tx_cmd_q;
        tx_data_d   = tx_data_q;
        last_err_d  = last_err_q;
        host_clr_d  = 1'b0;
        cpu_busy_d  = cpu_busy_q;
        cpu_len2_d  = cpu_len2_q;
        cpu_cmd_d   = cpu_cmd_q;
        cpu_data_d  = cpu_data_q;
        cpu_stat_d  = cpu_stat_q;
        txn_end     = 1'b0;
        txn_pass    = 1'b0;

        if (cpu_req_i && !cpu_busy_q) begin
            cpu_busy_d = 1'b1;
            cpu_stat_d = STAT_PEND;
            cpu_len2_d = cpu_len2_i;
            cpu_cmd_d  = cpu_cmd_i;
            cpu_data_d = cpu_data_i;
        end

        case (state_q)
            ST_IDLE: begin
                if (init_run_q) begin
                    src_d   = SRC_INIT;
                    state_d = ST_ISSUE0;
                    case (step_q)
                        2'd0:    begin tx_len2_d = 1'b1; tx_cmd_d = CMD_TYPEMATIC; tx_data_d = DEF_TYPEMATIC; end
                        2'd1:    begin tx_len2_d = 1'b1; tx_cmd_d = CMD_SET_LED; tx_data_d = {5'b0, led_i}; end
                        default: begin tx_len2_d = 1'b0; tx_cmd_d = CMD_ENABLE; tx_data_d = 8'h00; end
                    endcase
                end else if (cpu_busy_q) begin
                    src_d     = SRC_CPU;
                    state_d   = ST_ISSUE0;
                    tx_len2_d = cpu_len2_q;
                    tx_cmd_d  = cpu_cmd_q;
                    tx_data_d = cpu_data_q;
                end else if (init_done_q && led_i != led_sent_q) begin
                    src_d     = SRC_LED;
                    state_d   = ST_ISSUE0;
                    tx_len2_d = 1'b1;
                    tx_cmd_d  = CMD_SET_LED;
                    tx_data_d = {5'b0, led_i};
                end
            end
            ST_ISSUE0: state_d = tx_len2_q ? ST_ISSUE1 : ST_WAIT;
            ST_ISSUE1: state_d = ST_WAIT;
            ST_WAIT: begin
                if (kbd_stat_i == STAT_ACK) begin
                    txn_end  = 1'b1;
                    txn_pass = 1'b1;
                end else if (kbd_stat_i == STAT_ERR) begin
                    last_err_d = 1'b1;
                    state_d    = ST_RETRY;
                end else if (tmr_done) begin
                    // Only a timeout needs the host flushed; on ERR it flushes itself.
                    last_err_d = 1'b0;
                    host_clr_d = 1'b1;
                    state_d    = ST_RETRY;
                end
            end
            ST_RETRY: begin
                if (retry_q < 2'(MAX_RETRY)) begin
                    retry_d = retry_q + 2'd1;
                    state_d = ST_ISSUE0;
                end else begin
                    txn_end = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (txn_end) begin
            state_d = ST_IDLE;
            retry_d = 2'd0;
            case (src_q)
                SRC_INIT: begin
                    if (!txn_pass) init_err_d = 1'b1;
                    if (txn_pass && step_q == 2'd1) led_sent_d = tx_data_q[2:0];
                    if (step_q == 2'd2) begin
                        step_d      = 2'd0;
                        init_run_d  = 1'b0;
                        init_done_d = 1'b1;
                    end else begin
                        step_d = step_q + 2'd1;
                    end
                end
                SRC_CPU: begin
                    cpu_busy_d = 1'b0;
                    cpu_stat_d = txn_pass ? STAT_ACK : (last_err_q ? STAT_ERR : STAT_TMO);
                end
                SRC_LED: led_sent_d = tx_data_q[2:0];
                default: ;
            endcase
        end

        // Keyboard re-powered: drop everything in flight and restart init.
        if (kbd_bat_ok_i) begin
            host_clr_d  = 1'b1;
            state_d     = ST_IDLE;
            init_run_d  = 1'b1;
            init_done_d = 1'b0;
            init_err_d  = 1'b0;
            step_d      = 2'd0;
            retry_d     = 2'd0;
            led_sent_d  = led_sent_q;
            if (state_q != ST_IDLE && src_q == SRC_CPU) begin
                cpu_busy_d = 1'b0;
                cpu_stat_d = STAT_ERR;
            end
        end
    end

    always_ff @(posedge clk6x) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            src_q       <= SRC_NONE;
            step_q      <= '0;
            retry_q     <= '0;
            init_run_q  <= 1'b0;
            init_done_q <= 1'b0;
            init_err_q  <= 1'b0;
            led_sent_q  <= '0;
            tx_len2_q   <= 1'b0;
            tx_cmd_q    <= '0;
            tx_data_q   <= '0;
            last_err_q  <= 1'b0;
            host_clr_q  <= 1'b0;
            cpu_busy_q  <= 1'b0;
            cpu_len2_q  <= 1'b0;
            cpu_cmd_q   <= '0;
            cpu_data_q  <= '0;
            cpu_stat_q  <= STAT_IDLE;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            step_q      <= step_d;
            retry_q     <= retry_d;
            init_run_q  <= init_run_d;
            init_done_q <= init_done_d;
            init_err_q  <= init_err_d;
            led_sent_q  <= led_sent_d;
            tx_len2_q   <= tx_len2_d;
            tx_cmd_q    <= tx_cmd_d;
            tx_data_q   <= tx_data_d;
            last_err_q  <= last_err_d;
            host_clr_q  <= host_clr_d;
            cpu_busy_q  <= cpu_busy_d;
            cpu_len2_q  <= cpu_len2_d;
            cpu_cmd_q   <= cpu_cmd_d;
            cpu_data_q  <= cpu_data_d;
            cpu_stat_q  <= cpu_stat_d;
        end
    end

    assign kbd_enq_cmd2_o = (state_q == ST_ISSUE0) && tx_len2_q;
    assign kbd_enq_cmd1_o = ((state_q == ST_ISSUE0) && !tx_len2_q) || (state_q == ST_ISSUE1);
    assign kbd_wcmddata_o = (state_q == ST_ISSUE1) ? tx_data_q :
                            (state_q == ST_ISSUE0) ? tx_cmd_q  : 8'h00;
    assign host_clr_o     = host_clr_q;
    assign cpu_busy_o     = cpu_busy_q;
    assign cpu_stat_o     = cpu_stat_q;
    assign init_done_o    = init_done_q;
    assign init_err_o     = init_err_q;

endmodule

// File: tb/tb_ps2_kbd_cmd_sched.sv
// Bench for ps2_kbd_cmd_sched: a scripted host model answers each enqueued
// command after a configurable delay; CPU transactions are table-driven.
module tb_ps2_kbd_cmd_sched;

    logic       clk6x = 1'b0;
    logic       resetn = 1'b0;
    logic       ck1us = 1'b1;
    logic [7:0] kbd_stat = 8'h00;
    logic       bat_ok = 1'b0;
    logic [7:0] wdata;
    logic       enq1, enq2, host_clr;
    logic       cpu_req = 1'b0;
    logic       cpu_len2 = 1'b0;
    logic [7:0] cpu_cmd = 8'h00;
    logic [7:0] cpu_data = 8'h00;
    logic       cpu_busy;
    logic [7:0] cpu_stat;
    logic [2:0] led = 3'b000;
    logic       init_done, init_err;

    int checks = 0;
    int errors = 0;

    ps2_kbd_cmd_sched #(.TIMEOUT_MS(20), .MAX_RETRY(2), .DEF_TYPEMATIC(8'h20)) dut (
        .clk6x          (clk6x),
        .resetn         (resetn),
        .ck1us          (ck1us),
        .kbd_stat_i     (kbd_stat),
        .kbd_bat_ok_i   (bat_ok),
        .kbd_wcmddata_o (wdata),
        .kbd_enq_cmd1_o (enq1),
        .kbd_enq_cmd2_o (enq2),
        .host_clr_o     (host_clr),
        .cpu_req_i      (cpu_req),
        .cpu_len2_i     (cpu_len2),
        .cpu_cmd_i      (cpu_cmd),
        .cpu_data_i     (cpu_data),
        .cpu_busy_o     (cpu_busy),
        .cpu_stat_o     (cpu_stat),
        .led_i          (led),
        .init_done_o    (init_done),
        .init_err_o     (init_err)
    );

    always #5 clk6x = ~clk6x;

    // Host model: logs enqueued bytes, goes pending on the final byte, then
    // after reply_dly cycles presents the next scripted reply (01 = never answer).
    logic [8:0] log_q[$];
    logic [7:0] reply_q[$];
    int         reply_dly = 0;
    int         cyc = 0;
    int         n_cmd1 = 0;
    int         n_clr = 0;
    int         clr_cyc_q[$];
    int         cnt = 0;
    logic       counting = 1'b0;
    logic [7:0] pend = 8'h00;

    always @(posedge clk6x) begin
        cyc <= cyc + 1;
        if (!resetn) begin
            kbd_stat <= 8'h00;
            counting <= 1'b0;
        end else begin
            if (enq2) log_q.push_back({1'b1, wdata});
            if (enq1) begin
                log_q.push_back({1'b0, wdata});
                n_cmd1   <= n_cmd1 + 1;
                kbd_stat <= 8'h01;
                pend     <= (reply_q.size() > 0) ? reply_q.pop_front() : 8'h01;
                cnt      <= reply_dly;
                counting <= 1'b1;
            end else if (host_clr) begin
                kbd_stat <= 8'h00;
                counting <= 1'b0;
            end else if (counting) begin
                if (cnt == 0) begin
                    kbd_stat <= pend;
                    counting <= 1'b0;
                end else begin
                    cnt <= cnt - 1;
                end
            end
            if (host_clr) begin
                n_clr <= n_clr + 1;
                clr_cyc_q.push_back(cyc);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int val, input int lo, input int hi);
        checks++;
        if (val < lo || val > hi) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, val, lo, hi);
        end
    endtask

    task automatic log_at(input string name, input int idx, input logic [8:0] exp);
        logic [8:0] v;
        v = (idx < log_q.size()) ? log_q[idx] : 9'h1FF;
        check(name, 32'(v), 32'(exp));
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk6x);
    endtask

    task automatic cpu_issue(input logic l2, input logic [7:0] c, input logic [7:0] d);
        cpu_req = 1'b1; cpu_len2 = l2; cpu_cmd = c; cpu_data = d;
        tick(1);
        cpu_req = 1'b0;
    endtask

    task automatic wait_busy_low(input int budget);
        int n = 0;
        while (cpu_busy !== 1'b0 && n < budget) begin tick(1); n++; end
        check("busy_released", 32'(cpu_busy), 32'd0);
    endtask

    task automatic wait_init_done(input int budget);
        int n = 0;
        while (init_done !== 1'b1 && n < budget) begin tick(1); n++; end
        check("init_done", 32'(init_done), 32'd1);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_ctl"}, 32'({enq1, enq2, host_clr, cpu_busy, init_done, init_err}), 32'd0);
        check({name, "_wdata"}, 32'(wdata), 32'd0);
        check({name, "_stat"}, 32'(cpu_stat), 32'h00);
    endtask

    typedef struct {
        logic        len2;
        logic [7:0]  cmd;
        logic [7:0]  data;
        logic [31:0] rep;
        int          nrep;
        int          dly;
        logic [7:0]  exp_stat;
        int          exp_iss;
        int          exp_clr;
        int          min_cyc;
        int          max_cyc;
    } vec_t;

    vec_t       vecs[5];
    logic [8:0] exp_init[5];

    initial begin
        int s_cmd1, s_clr, t0, el;

        vecs[0] = '{1'b0, 8'hF2, 8'h00, 32'hFA000000, 1, 5000, 8'hFA, 1, 0, 5000, 5100};
        vecs[1] = '{1'b1, 8'hED, 8'h07, 32'hFEFEFA00, 3, 100, 8'hFA, 3, 0, 300, 400};
        vecs[2] = '{1'b1, 8'hF0, 8'h02, 32'hFEFEFE00, 3, 50, 8'hFE, 3, 0, 150, 250};
        vecs[3] = '{1'b0, 8'hEE, 8'h00, 32'h01010100, 3, 0, 8'hFD, 3, 3, 59000, 61100};
        vecs[4] = '{1'b0, 8'hF5, 8'h00, 32'hFEFA0000, 2, 20, 8'hFA, 2, 0, 40, 100};
        exp_init[0] = {1'b1, 8'hF3};
        exp_init[1] = {1'b0, 8'h20};
        exp_init[2] = {1'b1, 8'hED};
        exp_init[3] = {1'b0, 8'h00};
        exp_init[4] = {1'b0, 8'hF4};

        // Reset state, and nothing happens before BAT OK.
        tick(5);
        check_reset_outputs("reset");
        resetn = 1'b1;
        tick(50);
        check("no_traffic_before_bat", 32'(log_q.size()), 32'd0);
        $display("reset: stat=%0h busy=%0b init_done=%0b", cpu_stat, cpu_busy, init_done);

        // Init sequence, every step ACKed after 3 ms.
        reply_q = '{8'hFA, 8'hFA, 8'hFA};
        reply_dly = 3000;
        bat_ok = 1'b1; tick(1); bat_ok = 1'b0;
        wait_init_done(20000);
        check("init_log_len", 32'(log_q.size()), 32'd5);
        for (int i = 0; i < 5; i++) log_at("init_seq", i, exp_init[i]);
        check("init_err_clean", 32'(init_err), 32'd0);
        $display("init: %0d enqueues, done=%0b err=%0b", log_q.size(), init_done, init_err);

        // CPU transactions from the table.
        for (int v = 0; v < 5; v++) begin
            tick(5);
            log_q.delete();
            clr_cyc_q.delete();
            for (int k = 0; k < vecs[v].nrep; k++) reply_q.push_back(vecs[v].rep[31-8*k -: 8]);
            reply_dly = vecs[v].dly;
            s_cmd1 = n_cmd1;
            s_clr = n_clr;
            t0 = cyc;
            cpu_issue(vecs[v].len2, vecs[v].cmd, vecs[v].data);
            check("cpu_busy_set", 32'(cpu_busy), 32'd1);
            check("cpu_stat_pend", 32'(cpu_stat), 32'h01);
            wait_busy_low(80000);
            el = cyc - t0;
            check("cpu_stat_final", 32'(cpu_stat), 32'(vecs[v].exp_stat));
            check("cpu_issues", 32'(n_cmd1 - s_cmd1), 32'(vecs[v].exp_iss));
            check("cpu_host_clr", 32'(n_clr - s_clr), 32'(vecs[v].exp_clr));
            check_range("cpu_elapsed", el, vecs[v].min_cyc, vecs[v].max_cyc);
            if (vecs[v].len2) begin
                log_at("cpu_byte0", 0, {1'b1, vecs[v].cmd});
                log_at("cpu_byte1", 1, {1'b0, vecs[v].data});
            end else begin
                log_at("cpu_byte0", 0, {1'b0, vecs[v].cmd});
            end
            if (vecs[v].exp_clr > 0) begin
                check_range("first_timeout_clr", (clr_cyc_q.size() > 0) ? clr_cyc_q[0] - t0 : -1, 19000, 21000);
            end
            $display("cpu txn %0d: cmd=%0h stat=%0h issues=%0d clr=%0d cycles=%0d",
                     v, vecs[v].cmd, cpu_stat, n_cmd1 - s_cmd1, n_clr - s_clr, el);
        end

        // LED update after init, then a repeated write of the same value.
        tick(5);
        log_q.delete();
        reply_q = '{8'hFA};
        reply_dly = 100;
        led = 3'b100;
        for (int n = 0; n < 300 && log_q.size() < 2; n++) tick(1);
        tick(150);
        check("led_log_len", 32'(log_q.size()), 32'd2);
        log_at("led_cmd", 0, {1'b1, 8'hED});
        log_at("led_data", 1, {1'b0, 8'h04});
        led = 3'b100;
        tick(300);
        check("led_no_repeat", 32'(log_q.size()), 32'd2);
        $display("led: %0d enqueues", log_q.size());

        // BAT OK while a CPU transaction is waiting: abort as FE, restart init.
        reply_q = '{8'h01};
        reply_dly = 0;
        cpu_issue(1'b0, 8'hF2, 8'h00);
        tick(200);
        log_q.delete();
        reply_q = '{8'hFA, 8'hFA, 8'hFA};
        reply_dly = 100;
        bat_ok = 1'b1; tick(1); bat_ok = 1'b0;
        check("abort_busy", 32'(cpu_busy), 32'd0);
        check("abort_stat", 32'(cpu_stat), 32'hFE);
        check("abort_host_clr", 32'(host_clr), 32'd1);
        check("abort_init_done", 32'(init_done), 32'd0);
        wait_init_done(5000);
        check("reinit_log_len", 32'(log_q.size()), 32'd5);
        log_at("reinit_first", 0, {1'b1, 8'hF3});
        log_at("reinit_led", 3, {1'b0, 8'h04});
        $display("bat_ok abort: stat=%0h reinit %0d enqueues", cpu_stat, log_q.size());

        // BAT OK together with a CPU request; first init step fails outright.
        tick(5);
        log_q.delete();
        reply_q = '{8'hFE, 8'hFE, 8'hFE, 8'hFA, 8'hFA, 8'hFA};
        reply_dly = 20;
        bat_ok = 1'b1;
        cpu_issue(1'b0, 8'hF2, 8'h00);
        bat_ok = 1'b0;
        wait_busy_low(3000);
        check("queued_stat", 32'(cpu_stat), 32'hFA);
        check("queued_log_len", 32'(log_q.size()), 32'd10);
        log_at("queued_after_init", 9, {1'b0, 8'hF2});
        check("init_err_set", 32'(init_err), 32'd1);
        check("init_done_after_err", 32'(init_done), 32'd1);
        $display("bat_ok+req: stat=%0h init_err=%0b enqueues=%0d", cpu_stat, init_err, log_q.size());

        // Reset in the middle of a transaction.
        reply_q = '{8'h01};
        reply_dly = 0;
        cpu_issue(1'b0, 8'hEE, 8'h00);
        tick(100);
        resetn = 1'b0;
        tick(3);
        check_reset_outputs("midop_reset");
        resetn = 1'b1;
        log_q.delete();
        tick(50);
        check("no_traffic_after_reset", 32'(log_q.size()), 32'd0);
        $display("mid-op reset: stat=%0h busy=%0b", cpu_stat, cpu_busy);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
